ks_ram_responder: RTL and testbench
===================================

// Module: ks_ram_responder
// PURPOSE
//  Memory-side responder for the K&S CPU memory interface: a DEPTH x DATA_W word RAM.
//  It serves CPU read/write requests (address, write data, read data) through a
//  valid/ready request channel and a one-cycle rsp_valid strobe, with a configurable read latency.
//  A side load port preloads program/data words (boot or testbench) without CPU involvement.
//  Sits between the CPU control/data path and the program/data store.
// PARAMETERS
//  ADDR_W        5    word address width; DEPTH = 2**ADDR_W (32 words)
//  DATA_W        16   word width
//  READ_LATENCY  1    cycles from read accept edge to response edge; legal 1..4
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       CPU presents a request
//  req_ready  out  1       responder can accept a request this cycle
//  req_write  in   1       1 = write, 0 = read (sampled at accept)
//  ram_addr   in   ADDR_W  word address (sampled at accept)
//  wr_data    in   DATA_W  write data (sampled at accept)
//  rd_data    out  DATA_W  read data; valid while rsp_valid=1, held otherwise
//  rsp_valid  out  1       one-cycle strobe: read data ready / write acknowledged
//  load_en    in   1       load port write strobe
//  load_addr  in   ADDR_W  load port address
//  load_data  in   DATA_W  load port data
// BEHAVIOUR
//  - Reset (async assert, sync release by clk): state=IDLE, rsp_valid=0, rd_data=0, latency
//    counter=0, req_ready=0 while rst=1. RAM contents are NOT cleared by reset.
//  - Accept = req_valid & req_ready at a rising edge. req_ready = (state==IDLE) & ~load_en & ~rst.
//  - FSM states: IDLE, RD_WAIT, WR_ACK.
//    IDLE    : accept read  -> latch addr, cnt<=READ_LATENCY-1, go RD_WAIT.
//              accept write -> mem[ram_addr]<=wr_data at the accept edge, go WR_ACK.
//              no accept -> stay IDLE.
//    RD_WAIT : cnt!=0 -> cnt<=cnt-1. cnt==0 -> rd_data<=mem[addr_q], rsp_valid<=1, go IDLE.
//    WR_ACK  : rsp_valid<=1, go IDLE; rd_data unchanged.
//  - Timing: read accepted at edge N -> rd_data/rsp_valid registered at edge N+READ_LATENCY.
//    Write accepted at edge N -> rsp_valid at edge N+1.
//    rsp_valid is high exactly one cycle. req_ready is low for READ_LATENCY cycles after a read
//    accept and 1 cycle after a write accept. It is high again in the rsp_valid cycle, so
//    back-to-back reads accept every READ_LATENCY+1 cycles.
//  - Counter: 2 bits, loaded only at accept, never wraps (stops at 0).
//  - RAM read occurs at the response edge: it reflects every write (CPU or load) committed at
//    earlier edges. Read-after-write to the same address returns the new data.
//  - load_en: writes mem[load_addr]<=load_data at the edge, in any state.
//    Blocks new accepts in that cycle but does not disturb a pending read/ack.
//    Load at the same edge as the read-response edge, same address: the response returns the
//    OLD word; the new word is visible from the next edge.
//  - Full address range valid (DEPTH=2**ADDR_W); no out-of-range case; addresses do not wrap.
//  - rst asserted mid-operation: pending read/ack is discarded (no rsp_valid). A write already
//    committed at its accept edge stays in RAM.
//  - Request inputs are ignored outside accept cycles; X on them when req_valid=0 is harmless.
// TESTING
//  1 rst=1 for 3 cycles -> req_ready=0, rsp_valid=0, rd_data=16'h0000; after release
//    req_ready=1 in the first cycle.
//  2 L=1: load 16'h8105 @0, then read @0 -> rsp_valid 1 cycle after accept, rd_data=16'h8105,
//    req_ready low 1 cycle.
//  3 L=3: write 16'hA5A5 @31 (ack at N+1), then read @31 -> rsp_valid exactly 3 edges after
//    accept, rd_data=16'hA5A5, ready low 3 cycles.
//  4 L=3: read @5 (holds 16'h1111) pending; load 16'h2222 @5 one edge after accept -> response
//    rd_data=16'h2222.
//  5 L=2: read accepted, rst pulsed next cycle -> no rsp_valid ever; a prior write
//    16'h00FF @7 reads back 16'h00FF after reset.
//  6 L=1: req_valid held high, reads @1,@2,@3 (16'h0001..3) -> accepts every 2 cycles,
//    3 rsp_valid pulses with 16'h0001,16'h0002,16'h0003 in order.

Source files
------------

// File: rtl/ks_ram_if.sv
// ks_ram_if: CPU <-> memory responder bus for the K&S CPU.
//   Request channel : req_valid, req_ready, req_write, ram_addr, wr_data
//   Response channel: rd_data, rsp_valid (one-cycle strobe)
//   Side load port  : load_en, load_addr, load_data (boot/preload writes)
//   master = CPU / loader side, slave = memory responder side.
interface ks_ram_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rsp_valid;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (
        output req_valid, req_write, ram_addr, wr_data,
        output load_en, load_addr, load_data,
        input  req_ready, rd_data, rsp_valid
    );

    modport slave (
        input  req_valid, req_write, ram_addr, wr_data,
        input  load_en, load_addr, load_data,
        output req_ready, rd_data, rsp_valid
    );
endinterface

// File: rtl/ks_ram_responder.sv
// ks_ram_responder: DEPTH x DATA_W word RAM serving CPU read/write requests
// with a configurable read latency, plus a side load port for preloading.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (RAM contents are kept)
//   bus  - ks_ram_if.slave: request/response channels and load port
// Timing: read accepted at edge N responds at edge N+READ_LATENCY; write
// accepted at edge N is acknowledged at edge N+1. rsp_valid is a 1-cycle pulse.
module ks_ram_responder #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    ks_ram_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_ACK  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic accept_c;
    logic cpu_we_c;

    // Loads take the cycle: no new request is accepted while load_en is high.
    assign bus.req_ready = (state_q == IDLE) & ~bus.load_en & ~rst;
    assign accept_c      = bus.req_valid & bus.req_ready;
    assign cpu_we_c      = accept_c & bus.req_write;

    assign bus.rd_data   = rd_data_q;
    assign bus.rsp_valid = rsp_valid_q;

    // Single write port; load and CPU write are mutually exclusive via req_ready.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end else if (cpu_we_c) begin
            mem_q[bus.ram_addr] <= bus.wr_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rd_data_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state logic. The RAM is read at the response edge, so a load
    // landing on that same edge is not yet visible in the returned word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rd_data_d   = rd_data_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.req_write) begin
                        state_d = WR_ACK;
                    end else begin
                        addr_d  = bus.ram_addr;
                        cnt_d   = CNT_LOAD;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rd_data_d   = mem_q[addr_q];
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_ACK: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ks_ram_responder.sv
// tb_ks_ram_responder: directed bench for ks_ram_responder with three
// instances at READ_LATENCY 1, 2 and 3 sharing clock and reset.
module tb_ks_ram_responder;
    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;
    int pulses;

    ks_ram_if #(.ADDR_W(5), .DATA_W(16)) if1 ();
    ks_ram_if #(.ADDR_W(5), .DATA_W(16)) if2 ();
    ks_ram_if #(.ADDR_W(5), .DATA_W(16)) if3 ();

    ks_ram_responder #(.ADDR_W(5), .DATA_W(16), .READ_LATENCY(1)) u_l1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    ks_ram_responder #(.ADDR_W(5), .DATA_W(16), .READ_LATENCY(2)) u_l2 (
        .clk (clk), .rst (rst), .bus (if2)
    );
    ks_ram_responder #(.ADDR_W(5), .DATA_W(16), .READ_LATENCY(3)) u_l3 (
        .clk (clk), .rst (rst), .bus (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pulses       = 0;
        rst          = 1'b1;
        {if1.req_valid, if1.req_write, if1.ram_addr, if1.wr_data} = '0;
        {if1.load_en, if1.load_addr, if1.load_data} = '0;
        {if2.req_valid, if2.req_write, if2.ram_addr, if2.wr_data} = '0;
        {if2.load_en, if2.load_addr, if2.load_data} = '0;
        {if3.req_valid, if3.req_write, if3.ram_addr, if3.wr_data} = '0;
        {if3.load_en, if3.load_addr, if3.load_data} = '0;

        // 1: reset for 3 cycles
        tick();
        check("t1_ready_rst_c1", if1.req_ready, 0);
        tick();
        check("t1_rsp_rst_c2", if1.rsp_valid, 0);
        tick();
        check("t1_ready_rst_l1", if1.req_ready, 0);
        check("t1_ready_rst_l3", if3.req_ready, 0);
        check("t1_rsp_rst_l2", if2.rsp_valid, 0);
        check("t1_rdata_rst_l1", if1.rd_data, 16'h0000);
        check("t1_rdata_rst_l3", if3.rd_data, 16'h0000);
        rst = 1'b0;
        #1;
        check("t1_ready_after_rel_l1", if1.req_ready, 1);
        check("t1_ready_after_rel_l3", if3.req_ready, 1);

        // 2: L=1, load 8105 @0 then read @0
        if1.load_en = 1'b1; if1.load_addr = 5'd0; if1.load_data = 16'h8105;
        #1;
        check("t2_ready_blocked_by_load", if1.req_ready, 0);
        tick();
        if1.load_en = 1'b0;
        if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.ram_addr = 5'd0;
        #1;
        check("t2_ready_before_accept", if1.req_ready, 1);
        tick();
        if1.req_valid = 1'b0;
        check("t2_ready_low_after_accept", if1.req_ready, 0);
        check("t2_rsp_not_yet", if1.rsp_valid, 0);
        tick();
        check("t2_rsp_valid", if1.rsp_valid, 1);
        check("t2_rdata", if1.rd_data, 16'h8105);
        check("t2_ready_in_rsp_cycle", if1.req_ready, 1);
        tick();
        check("t2_rsp_one_cycle", if1.rsp_valid, 0);
        check("t2_rdata_held", if1.rd_data, 16'h8105);

        // 2b: L=1, load to same address on the response edge returns old word
        if1.req_valid = 1'b1; if1.ram_addr = 5'd0;
        tick();
        if1.req_valid = 1'b0;
        if1.load_en = 1'b1; if1.load_addr = 5'd0; if1.load_data = 16'hBEEF;
        tick();
        if1.load_en = 1'b0;
        check("t2b_rsp_valid", if1.rsp_valid, 1);
        check("t2b_old_word", if1.rd_data, 16'h8105);
        if1.req_valid = 1'b1; if1.ram_addr = 5'd0;
        tick();
        if1.req_valid = 1'b0;
        tick();
        check("t2b_rsp_valid_2", if1.rsp_valid, 1);
        check("t2b_new_word", if1.rd_data, 16'hBEEF);

        // 3: L=3, write A5A5 @31 then read @31
        if3.req_valid = 1'b1; if3.req_write = 1'b1; if3.ram_addr = 5'd31; if3.wr_data = 16'hA5A5;
        tick();
        if3.req_valid = 1'b0; if3.req_write = 1'b0;
        check("t3_wr_ready_low", if3.req_ready, 0);
        check("t3_wr_no_ack_yet", if3.rsp_valid, 0);
        tick();
        check("t3_wr_ack", if3.rsp_valid, 1);
        check("t3_wr_rdata_unchanged", if3.rd_data, 16'h0000);
        check("t3_wr_ready_back", if3.req_ready, 1);
        if3.req_valid = 1'b1; if3.ram_addr = 5'd31;
        tick();
        if3.req_valid = 1'b0;
        check("t3_rd_ready_low_1", if3.req_ready, 0);
        check("t3_rd_rsp_0_1", if3.rsp_valid, 0);
        tick();
        check("t3_rd_ready_low_2", if3.req_ready, 0);
        check("t3_rd_rsp_0_2", if3.rsp_valid, 0);
        tick();
        check("t3_rd_ready_low_3", if3.req_ready, 0);
        check("t3_rd_rsp_0_3", if3.rsp_valid, 0);
        tick();
        check("t3_rd_rsp_valid", if3.rsp_valid, 1);
        check("t3_rd_rdata", if3.rd_data, 16'hA5A5);
        check("t3_rd_ready_back", if3.req_ready, 1);
        tick();
        check("t3_rd_rsp_one_cycle", if3.rsp_valid, 0);

        // 4: L=3, load during pending read to same address is seen
        if3.load_en = 1'b1; if3.load_addr = 5'd5; if3.load_data = 16'h1111;
        tick();
        if3.load_en = 1'b0;
        if3.req_valid = 1'b1; if3.req_write = 1'b0; if3.ram_addr = 5'd5;
        tick();
        if3.req_valid = 1'b0;
        if3.load_en = 1'b1; if3.load_addr = 5'd5; if3.load_data = 16'h2222;
        tick();
        if3.load_en = 1'b0;
        check("t4_rsp_0_a", if3.rsp_valid, 0);
        tick();
        check("t4_rsp_0_b", if3.rsp_valid, 0);
        tick();
        check("t4_rsp_valid", if3.rsp_valid, 1);
        check("t4_rdata_new", if3.rd_data, 16'h2222);

        // 5: L=2, write 00FF @7, read aborted by reset, then read back
        if2.req_valid = 1'b1; if2.req_write = 1'b1; if2.ram_addr = 5'd7; if2.wr_data = 16'h00FF;
        tick();
        if2.req_valid = 1'b0; if2.req_write = 1'b0;
        tick();
        check("t5_wr_ack", if2.rsp_valid, 1);
        tick();
        if2.req_valid = 1'b1; if2.ram_addr = 5'd7;
        tick();
        if2.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_rst_rsp", if2.rsp_valid, 0);
        check("t5_rst_ready", if2.req_ready, 0);
        check("t5_rst_clears_rdata_l1", if1.rd_data, 16'h0000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_rsp_after_rst", if2.rsp_valid, 0);
        end
        if2.req_valid = 1'b1; if2.ram_addr = 5'd7;
        #1;
        check("t5_ready_after_rst", if2.req_ready, 1);
        tick();
        if2.req_valid = 1'b0;
        tick();
        check("t5_rd_rsp_0", if2.rsp_valid, 0);
        tick();
        check("t5_rd_rsp_valid", if2.rsp_valid, 1);
        check("t5_rd_rdata_kept", if2.rd_data, 16'h00FF);

        // 6: L=1, back-to-back reads with req_valid held high
        for (int i = 1; i <= 3; i++) begin
            if1.load_en = 1'b1; if1.load_addr = 5'(i); if1.load_data = 16'(i);
            tick();
        end
        if1.load_en = 1'b0;
        if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.ram_addr = 5'd1;
        #1;
        check("t6_ready_start", if1.req_ready, 1);
        tick();
        pulses += int'(if1.rsp_valid);
        check("t6_ready_low_1", if1.req_ready, 0);
        if1.ram_addr = 5'd2;
        tick();
        pulses += int'(if1.rsp_valid);
        check("t6_rsp_1", if1.rsp_valid, 1);
        check("t6_rdata_1", if1.rd_data, 16'h0001);
        check("t6_ready_high_1", if1.req_ready, 1);
        tick();
        pulses += int'(if1.rsp_valid);
        check("t6_ready_low_2", if1.req_ready, 0);
        if1.ram_addr = 5'd3;
        tick();
        pulses += int'(if1.rsp_valid);
        check("t6_rdata_2", if1.rd_data, 16'h0002);
        check("t6_ready_high_2", if1.req_ready, 1);
        tick();
        pulses += int'(if1.rsp_valid);
        if1.req_valid = 1'b0;
        tick();
        pulses += int'(if1.rsp_valid);
        check("t6_rsp_3", if1.rsp_valid, 1);
        check("t6_rdata_3", if1.rd_data, 16'h0003);
        tick();
        pulses += int'(if1.rsp_valid);
        check("t6_pulse_count", 32'(pulses), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
